regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port controller for the 8×16 LC-3 register file. It shares the single write port (LD_REG/DRMUX/D) between two writeback requesters (ALU path and memory-load path) using a round-robin valid/ready handshake. It also optionally sequences a bulk clear of R0–R7. It sits between the datapath writeback sources and the register file, and its registered outputs drive the register file's load, destination-select and data inputs directly.

## Interface
- DATA_W, 16, register width
- ADDR_W, 3, destination-register index width
- CLR_VALUE, 16'h0000, value written to each register during a clear
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 (ALU writeback) has a write pending
- req0_dr  input  ADDR_W  requester 0 destination register
- req0_data  input  DATA_W  requester 0 write data
- req0_ready  output  1  requester 0 write accepted this cycle (combinational)
- req1_valid / req1_dr / req1_data / req1_ready: same as above, for requester 1 (memory-load writeback)
- clr_start  input  1  single-cycle pulse; requests a clear of R0–R7
- busy  output  1  clear sequence in progress (registered)
- clr_done  output  1  one-cycle pulse after the last clear write is issued (registered)
- LD_REG  output  1  register-file load enable (registered)
- DRMUX  output  ADDR_W  register-file destination select (registered)
- D  output  DATA_W  register-file write data (registered)

## Operation
- FSM states: IDLE, CLEAR.
- IDLE, arbitration:
  - A transfer on requester i occurs when reqi_valid && reqi_ready.
  - Only one requester valid → it is granted.
  - Both valid → grant goes to the requester not granted most recently. After reset, requester 0 wins the first tie.
  - The last-grant pointer updates only on an actual grant.
  - At most one ready is high per cycle. No ready is asserted without a matching valid.
- On a grant, the next edge loads LD_REG=1, DRMUX=granted dr, D=granted data. With no grant, the next edge loads LD_REG=0; DRMUX and D hold.
- Same-DR writes from both requesters are serialized in grant order; the last write wins. No merging or forwarding.
- clr_start in IDLE:
  - Takes priority over any request in the same cycle; both readys stay low.
  - Transition to CLEAR with clear counter = 0.
- CLEAR:
  - Each cycle issues LD_REG=1, DRMUX=counter, D=CLR_VALUE, then increments the counter.
  - After index 7 is issued: return to IDLE, pulse clr_done for one cycle, drop busy.
  - Both readys are low throughout CLEAR.
  - clr_start during CLEAR is ignored (not queued).
- Reset (asynchronous, any state, including mid-clear):
  - State=IDLE, counter=0, LD_REG=0, DRMUX=0, D=0, busy=0, clr_done=0, last-grant pointer = requester 1.
  - Registers already cleared stay cleared. No restart of the clear sequence.

## Timing
- Handshake accepted in cycle N → LD_REG/DRMUX/D valid in cycle N+1 → register file updated at the end of N+1. Read-after-write through the register file is visible from cycle N+2.
- Sustained throughput: one write per cycle. With both requesters continuously valid, grants alternate 0,1,0,1…
- Clear: clr_start sampled in cycle N → writes to R0..R7 appear in cycles N+1..N+8. busy is high in cycles N+1..N+8; clr_done is high in cycle N+9; requests can be accepted from cycle N+9.
- ready depends combinationally on valid, state and the pointer. valid must not depend combinationally on ready.

## Configuration
- REGFILE_CLEAR_EN defined: CLEAR state, counter, clr_start, busy and clr_done are implemented as described.
- REGFILE_CLEAR_EN undefined:
  - The ports remain present.
  - clr_start is ignored; busy and clr_done are tied to 0.
  - The FSM reduces to IDLE only, and arbitration is always active.

## Structure
- Shared package regfile_pkg:
  - NUM_REGS=8, REG_W=16, REG_ADDR_W=3.
  - wb_state_t enum {IDLE, CLEAR}.
  - Typedef for a writeback request struct {dr, data}.
- Sub-module rr_arb2: a 2-way round-robin arbiter.
  - Inputs: req[1:0], enable.
  - Outputs: one-hot grant; last-grant pointer held internally.
  - Instantiated once; enable is low during CLEAR.

## Test plan
- Reset mid-traffic: assert Reset asynchronously between edges → LD_REG, DRMUX, D, busy, clr_done all 0 immediately. First subsequent tie is granted to requester 0.
- Single requester: req0 valid with dr=3, data=16'hBEEF for one cycle → req0_ready=1 the same cycle; next cycle LD_REG=1, DRMUX=3, D=16'hBEEF; the cycle after, LD_REG=0.
- Contention: both valid for 4 cycles (req0 dr=1 data=16'h1111, req1 dr=2 data=16'h2222) → DRMUX sequence 1,2,1,2, with no cycle where both readys are high.
- Clear: pulse clr_start with both requesters valid → readys low for 8 cycles. DRMUX=0..7 with D=16'h0000 and LD_REG=1; clr_done pulses once; requests then resume.
- Reset mid-clear: Reset asserted after the R3 write → state IDLE, busy=0, no clr_done; a new clr_start restarts from R0.
- Build without REGFILE_CLEAR_EN: clr_start pulse → no change in arbitration, busy=0, clr_done=0, requests are accepted in that same cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the LC-3 register-file write-port controller.
package regfile_pkg;

  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned REG_W      = 16;
  localparam int unsigned REG_ADDR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } wb_state_t;

  // One writeback request as presented to the register-file write port
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dr;
    logic [REG_W-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer only moves on a real grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       enable_i,
  output logic [1:0] gnt_c
);

  // last_q = 1 means requester 1 was granted most recently
  logic last_q;
  logic last_d;

  // Grant selection and pointer update
  always_comb begin
    gnt_c  = 2'b00;
    last_d = last_q;
    if (enable_i) begin
      case (req_i)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11:   gnt_c = last_q ? 2'b01 : 2'b10;
        default: gnt_c = 2'b00;
      endcase
      if (gnt_c[1]) begin
        last_d = 1'b1;
      end else if (gnt_c[0]) begin
        last_d = 1'b0;
      end
    end
  end

  // Pointer register; reset favours requester 0 on the first tie
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 8x16 LC-3 register file: round-robin
// arbitration between ALU and load writeback, plus an optional R0-R7 clear
// sequence enabled by the REGFILE_CLEAR_EN macro.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned       DATA_W    = REG_W,
  parameter int unsigned       ADDR_W    = REG_ADDR_W,
  parameter logic [DATA_W-1:0] CLR_VALUE = DATA_W'(16'h0000)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_dr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_dr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic              LD_REG,
  output logic [ADDR_W-1:0] DRMUX,
  output logic [DATA_W-1:0] D
);

  logic [1:0]        gnt_c;
  logic              arb_en_c;
  wb_req_t           sel_c;

  logic              ld_q, ld_d;
  logic [ADDR_W-1:0] dr_q, dr_d;
  logic [DATA_W-1:0] data_q, data_d;

  rr_arb2 u_arb (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .req_i    ({req1_valid, req0_valid}),
    .enable_i (arb_en_c),
    .gnt_c    (gnt_c)
  );

  assign req0_ready = gnt_c[0];
  assign req1_ready = gnt_c[1];

  // Payload of whichever requester holds the grant
  always_comb begin
    sel_c.dr   = REG_ADDR_W'(req0_dr);
    sel_c.data = REG_W'(req0_data);
    if (gnt_c[1]) begin
      sel_c.dr   = REG_ADDR_W'(req1_dr);
      sel_c.data = REG_W'(req1_data);
    end
  end

`ifdef REGFILE_CLEAR_EN
  wb_state_t             state_q, state_d;
  logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // A clear request in IDLE pre-empts any same-cycle writeback
  assign arb_en_c = (state_q == IDLE) && !clr_start;

  // Next state and write-port outputs; cnt_q tracks the last index issued
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ld_d    = 1'b0;
    dr_d    = dr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
          ld_d    = 1'b1;
          dr_d    = '0;
          data_d  = CLR_VALUE;
        end else if (|gnt_c) begin
          ld_d   = 1'b1;
          dr_d   = ADDR_W'(sel_c.dr);
          data_d = DATA_W'(sel_c.data);
        end
      end
      CLEAR: begin
        if (cnt_q == REG_ADDR_W'(NUM_REGS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + REG_ADDR_W'(1);
          ld_d   = 1'b1;
          dr_d   = ADDR_W'(cnt_d);
          data_d = CLR_VALUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear-sequence state registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign clr_done = done_q;
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start;

  // Arbitration is permanently enabled without the clear feature
  assign arb_en_c = 1'b1;

  // Write-port outputs follow the grant directly
  always_comb begin
    ld_d   = 1'b0;
    dr_d   = dr_q;
    data_d = data_q;
    if (|gnt_c) begin
      ld_d   = 1'b1;
      dr_d   = ADDR_W'(sel_c.dr);
      data_d = DATA_W'(sel_c.data);
    end
  end

  assign busy     = 1'b0;
  assign clr_done = 1'b0;
`endif

  // Registered register-file write port
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ld_q   <= 1'b0;
      dr_q   <= '0;
      data_q <= '0;
    end else begin
      ld_q   <= ld_d;
      dr_q   <= dr_d;
      data_q <= data_d;
    end
  end

  assign LD_REG = ld_q;
  assign DRMUX  = dr_q;
  assign D      = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (both REGFILE_CLEAR_EN builds).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_dr, req1_dr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        clr_start;
  logic        busy, clr_done, ld_reg;
  logic [2:0]  drmux;
  logic [15:0] d_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  regfile_wb_arbiter dut (
    .Clk        (clk),
    .Reset      (rst),
    .req0_valid (req0_valid),
    .req0_dr    (req0_dr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_dr    (req1_dr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .clr_start  (clr_start),
    .busy       (busy),
    .clr_done   (clr_done),
    .LD_REG     (ld_reg),
    .DRMUX      (drmux),
    .D          (d_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input logic [31:0] ld, input logic [31:0] dr,
                            input logic [31:0] dat);
    check_eq({tag, "_ld"}, 32'(ld_reg), ld);
    check_eq({tag, "_dr"}, 32'(drmux), dr);
    check_eq({tag, "_d"},  32'(d_out), dat);
  endtask

  initial begin
    req0_valid = 1'b0; req0_dr = 3'd0; req0_data = 16'h0;
    req1_valid = 1'b0; req1_dr = 3'd0; req1_data = 16'h0;
    clr_start  = 1'b0;

    // reset state
    #2;
    check_port("rst", 32'd0, 32'd0, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(clr_done), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // contention right after reset: 0,1,0,1
    req0_valid = 1'b1; req0_dr = 3'd1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_dr = 3'd2; req1_data = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("cont_rdy0", 32'(req0_ready), 32'(k % 2 == 0));
      check_eq("cont_rdy1", 32'(req1_ready), 32'(k % 2 == 1));
      check_eq("cont_both", 32'(req0_ready & req1_ready), 32'd0);
      tick();
      if (k % 2 == 0) check_port("cont", 32'd1, 32'd1, 32'h1111);
      else            check_port("cont", 32'd1, 32'd2, 32'h2222);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check_eq("idle_rdy", 32'({req1_ready, req0_ready}), 32'd0);

    // single requester 0
    req0_valid = 1'b1; req0_dr = 3'd3; req0_data = 16'hBEEF;
    #1;
    check_eq("single_rdy0", 32'(req0_ready), 32'd1);
    check_eq("single_rdy1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    check_port("single_wr", 32'd1, 32'd3, 32'hBEEF);
    tick();
    check_port("single_hold", 32'd0, 32'd3, 32'hBEEF);

    // single requester 1
    req1_valid = 1'b1; req1_dr = 3'd5; req1_data = 16'h5555;
    #1;
    check_eq("r1_rdy1", 32'(req1_ready), 32'd1);
    check_eq("r1_rdy0", 32'(req0_ready), 32'd0);
    tick();
    req1_valid = 1'b0;
    check_port("r1_wr", 32'd1, 32'd5, 32'h5555);

    // reset mid-traffic: pointer returns to favour requester 0
    req0_valid = 1'b1; req0_dr = 3'd1; req0_data = 16'h1111;
    req1_valid = 1'b1; req1_dr = 3'd2; req1_data = 16'h2222;
    #1;
    check_eq("pre_rst_rdy0", 32'(req0_ready), 32'd1);
    tick();
    check_eq("pre_rst_rdy1", 32'(req1_ready), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_port("async_rst", 32'd0, 32'd0, 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_done", 32'(clr_done), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_rdy0", 32'(req0_ready), 32'd1);
    check_eq("post_rst_rdy1", 32'(req1_ready), 32'd0);
    tick();
    check_port("post_rst_wr", 32'd1, 32'd1, 32'h1111);

`ifdef REGFILE_CLEAR_EN
    // clear with both requesters valid (pointer now favours requester 1)
    clr_start = 1'b1;
    #1;
    check_eq("clr_start_rdy", 32'({req1_ready, req0_ready}), 32'd0);
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) clr_start = 1'b1;
      #1;
      check_eq("clr_rdy", 32'({req1_ready, req0_ready}), 32'd0);
      check_port("clr", 32'd1, 32'(i), 32'h0000);
      check_eq("clr_busy", 32'(busy), 32'd1);
      check_eq("clr_done_early", 32'(clr_done), 32'd0);
      tick();
      clr_start = 1'b0;
    end
    check_eq("clr_done", 32'(clr_done), 32'd1);
    check_eq("clr_busy_end", 32'(busy), 32'd0);
    check_eq("clr_ld_end", 32'(ld_reg), 32'd0);
    check_eq("clr_resume_rdy1", 32'(req1_ready), 32'd1);
    check_eq("clr_resume_rdy0", 32'(req0_ready), 32'd0);
    tick();
    check_eq("clr_done_pulse", 32'(clr_done), 32'd0);
    check_eq("clr_busy_after", 32'(busy), 32'd0);
    check_port("clr_resume", 32'd1, 32'd2, 32'h2222);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // reset mid-clear, then a fresh clear restarts from R0
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick(); tick(); tick();
    check_port("mid_clr_r3", 32'd1, 32'd3, 32'h0000);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ld", 32'(ld_reg), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("mid_rst_nodone", 32'(clr_done), 32'd0);
    check_eq("mid_rst_nobusy", 32'(busy), 32'd0);
    check_eq("mid_rst_norestart", 32'(ld_reg), 32'd0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_port("reclr", 32'd1, 32'(i), 32'h0000);
      tick();
    end
    check_eq("reclr_done", 32'(clr_done), 32'd1);
`else
    // clr_start is ignored: grant proceeds in the same cycle
    clr_start = 1'b1;
    #1;
    check_eq("noclr_rdy1", 32'(req1_ready), 32'd1);
    check_eq("noclr_rdy0", 32'(req0_ready), 32'd0);
    tick();
    clr_start = 1'b0;
    check_port("noclr_wr", 32'd1, 32'd2, 32'h2222);
    check_eq("noclr_busy", 32'(busy), 32'd0);
    check_eq("noclr_done", 32'(clr_done), 32'd0);
    tick();
    check_eq("noclr_done2", 32'(clr_done), 32'd0);
    check_port("noclr_alt", 32'd1, 32'd1, 32'h1111);
    req0_valid = 1'b0; req1_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
